sys_id_ctrl: RTL and testbench

- Parametrised Avalon-MM system-identification slave; successor to the fixed two-word ID block.
- Returns system ID, build timestamp and version words; adds a read/write scratch register, a free-running 64-bit cycle counter with coherent snapshot reads, and a seconds uptime counter.
- Sits on the Nios II data master bus next to the clock peripherals. Software uses it for image identification, bus sanity checks and coarse timing.

---
 rtl/sys_id_pkg.sv | 24 ++
 rtl/sys_id_rd_pipe.sv | 26 ++
 rtl/sys_id_ctrl.sv | 106 ++++++++++
 tb/tb_sys_id_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_id_pkg.sv
// Shared definitions for the system-ID slave: register map, CTRL bit positions,
// the default version word and the read-pipeline beat type.
package sys_id_pkg;

   localparam logic [2:0] ADDR_ID        = 3'd0;
   localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
   localparam logic [2:0] ADDR_VERSION   = 3'd2;
   localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
   localparam logic [2:0] ADDR_UPTIME    = 3'd4;
   localparam logic [2:0] ADDR_CYC_LO    = 3'd5;
   localparam logic [2:0] ADDR_CYC_HI    = 3'd6;
   localparam logic [2:0] ADDR_CTRL      = 3'd7;

   localparam int CTRL_CLR    = 0;
   localparam int CTRL_FREEZE = 1;

   localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } rd_beat_t;

endpackage

// File: rtl/sys_id_rd_pipe.sv
// Fixed-latency read-return pipeline: LAT stages of {valid, data}, flushed by reset.
module sys_id_rd_pipe
   import sys_id_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     clock,
   input  logic     reset,
   input  rd_beat_t beat_i,
   output rd_beat_t beat_o
);

   rd_beat_t stage_q [LAT];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= beat_i;
         for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign beat_o = stage_q[LAT-1];

endmodule

// File: rtl/sys_id_ctrl.sv
// Avalon-MM system-identification slave: constant ID words, scratch register,
// 64-bit cycle counter with coherent high-word snapshot, and a seconds uptime counter.
module sys_id_ctrl
   import sys_id_pkg::*;
#(
   parameter logic [31:0] SYS_ID       = 32'h6537_1B35,
   parameter logic [31:0] TIMESTAMP    = 32'd1698501301,
   parameter logic [31:0] VERSION      = VERSION_DEFAULT,
   parameter logic [31:0] CLK_HZ       = 32'd50_000_000,
   parameter int          ADDR_W       = 3,
   parameter int          READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   logic [63:0] cyc_q;
   logic [31:0] snap_q;
   logic [31:0] scratch_q;
   logic [31:0] presc_q, presc_d;
   logic [31:0] uptime_q, uptime_d;
   logic        freeze_q;

   logic        in_map;
   logic [2:0]  reg_idx;
   logic        wr_en;
   logic        clr;
   rd_beat_t    rd_beat;
   rd_beat_t    rd_out;

   assign in_map  = (address >> 3) == '0;
   assign reg_idx = address[2:0];
   // A simultaneous read wins; the write is dropped.
   assign wr_en   = write && !read && in_map;
   assign clr     = wr_en && (reg_idx == ADDR_CTRL) && writedata[CTRL_CLR];

   always_comb begin
      rd_beat       = '0;
      rd_beat.valid = read;
      if (read && in_map) begin
         case (reg_idx)
            ADDR_ID:        rd_beat.data = SYS_ID;
            ADDR_TIMESTAMP: rd_beat.data = TIMESTAMP;
            ADDR_VERSION:   rd_beat.data = VERSION;
            ADDR_SCRATCH:   rd_beat.data = scratch_q;
            ADDR_UPTIME:    rd_beat.data = uptime_q;
            ADDR_CYC_LO:    rd_beat.data = cyc_q[31:0];
            ADDR_CYC_HI:    rd_beat.data = snap_q;
            ADDR_CTRL:      rd_beat.data[CTRL_FREEZE] = freeze_q;
            default:        rd_beat.data = '0;
         endcase
      end
   end

   // Clear beats both the prescaler wrap and freeze.
   always_comb begin
      presc_d  = presc_q;
      uptime_d = uptime_q;
      if (clr) begin
         presc_d  = '0;
         uptime_d = '0;
      end else if (!freeze_q) begin
         if (presc_q == CLK_HZ - 32'd1) begin
            presc_d  = '0;
            uptime_d = uptime_q + 32'd1;
         end else begin
            presc_d = presc_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q     <= '0;
         snap_q    <= '0;
         scratch_q <= '0;
         presc_q   <= '0;
         uptime_q  <= '0;
         freeze_q  <= 1'b0;
      end else begin
         cyc_q    <= cyc_q + 64'd1;
         presc_q  <= presc_d;
         uptime_q <= uptime_d;
         if (read && in_map && (reg_idx == ADDR_CYC_LO)) snap_q <= cyc_q[63:32];
         if (wr_en && (reg_idx == ADDR_SCRATCH)) scratch_q <= writedata;
         if (wr_en && (reg_idx == ADDR_CTRL)) freeze_q <= writedata[CTRL_FREEZE];
      end
   end

   sys_id_rd_pipe #(.LAT(READ_LATENCY)) u_rd_pipe (
      .clock  (clock),
      .reset  (reset),
      .beat_i (rd_beat),
      .beat_o (rd_out)
   );

   assign readdata      = rd_out.data;
   assign readdatavalid = rd_out.valid;

endmodule

// File: tb/tb_sys_id_ctrl.sv
// Bench for sys_id_ctrl: two instances (read latency 2 and 3) share stimulus and
// are compared every cycle against a register-level model, plus literal expectations.
module tb_sys_id_ctrl;

   localparam logic [31:0] P_ID  = 32'h6537_1B35;
   localparam logic [31:0] P_TS  = 32'd1698501301;
   localparam logic [31:0] P_VER = 32'h0002_0000;
   localparam int          HZ    = 10;
   localparam int          HLEN  = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  address = 4'd0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] rdd2, rdd3;
   logic        rdv2, rdv3;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sys_id_ctrl #(.CLK_HZ(32'd10), .ADDR_W(4), .READ_LATENCY(2)) dut (
      .clock(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rdd2), .readdatavalid(rdv2)
   );

   sys_id_ctrl #(.CLK_HZ(32'd10), .ADDR_W(4), .READ_LATENCY(3)) dut3 (
      .clock(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rdd3), .readdatavalid(rdv3)
   );

   // ---------------- register-level model ----------------
   logic [31:0] m_scratch = '0, m_presc = '0, m_up = '0, m_snap = '0;
   logic [63:0] m_cyc = '0;
   logic        m_freeze = 1'b0;
   int          n_e = 0;
   bit          rec_rd  [HLEN];
   bit          rec_rst [HLEN];
   logic [31:0] rec_dat [HLEN];

   function automatic logic [31:0] model_rd(input logic [3:0] a);
      if (a >= 4'd8) return 32'h0;
      case (a)
         4'd0: return P_ID;
         4'd1: return P_TS;
         4'd2: return P_VER;
         4'd3: return m_scratch;
         4'd4: return m_up;
         4'd5: return m_cyc[31:0];
         4'd6: return m_snap;
         default: return {30'b0, m_freeze, 1'b0};
      endcase
   endfunction

   always @(posedge clk) begin : model
      int  idx;
      bit  wr, clr;
      n_e = n_e + 1;
      idx = n_e % HLEN;
      rec_rst[idx] = reset;
      rec_rd[idx]  = read && !reset;
      rec_dat[idx] = model_rd(address);
      if (reset) begin
         m_scratch = '0; m_presc = '0; m_up = '0; m_snap = '0; m_cyc = '0; m_freeze = 1'b0;
      end else begin
         wr  = write && !read;
         clr = wr && address == 4'd7 && writedata[0];
         if (read && address == 4'd5) m_snap = m_cyc[63:32];
         m_cyc = m_cyc + 64'd1;
         if (clr) begin
            m_presc = '0; m_up = '0;
         end else if (!m_freeze) begin
            if (m_presc == 32'(HZ - 1)) begin m_presc = '0; m_up = m_up + 32'd1; end
            else m_presc = m_presc + 32'd1;
         end
         if (wr && address == 4'd3) m_scratch = writedata;
         if (wr && address == 4'd7) m_freeze = writedata[1];
      end
   end

   // A read accepted at edge s is due after edge s+L-1 unless reset hit in between.
   function automatic bit exp_valid(input int lat);
      int s;
      s = n_e - lat + 1;
      if (s < 1) return 1'b0;
      if (!rec_rd[s % HLEN]) return 1'b0;
      for (int k = s + 1; k <= n_e; k++) if (rec_rst[k % HLEN]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cmp(input string nm, input logic v, input logic [31:0] d, input int lat);
      bit          ev;
      logic [31:0] ed;
      ev = exp_valid(lat);
      ed = ev ? rec_dat[(n_e - lat + 1) % HLEN] : 32'h0;
      checks++;
      if (v !== ev || d !== ed) begin
         errors++;
         $display("FAIL %s edge %0d: got valid=%0b data=%h, want valid=%0b data=%h",
                  nm, n_e, v, d, ev, ed);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("model_l2", rdv2, rdd2, 2);
         cmp("model_l3", rdv3, rdd3, 3);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] want,
                         input bit also_wr = 1'b0, input logic [31:0] wd = 32'h0);
      bit          ok;
      logic [31:0] d;
      address = a; read = 1'b1; write = also_wr; writedata = wd;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      ok = 1'b0; d = 32'h0;
      for (int i = 0; i < 6 && !ok; i++) begin
         @(negedge clk);
         if (rdv2) begin ok = 1'b1; d = rdd2; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got no readdatavalid, want data %h", nm, want);
      end else if (d !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, d, want);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          gv [6];
      logic [31:0] gd [6];
      int          npulse;

      @(negedge clk);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      chk_en = 1'b1;
      lit("rst_valid", {31'b0, rdv2}, 32'h0);
      lit("rst_data", rdd2, 32'h0);

      // uptime, freeze and clear (prescaler terminal count 10)
      idle(35);
      rd_chk("uptime_35", 4'd4, 32'd3);
      wr(4'd7, 32'h2);
      idle(50);
      rd_chk("uptime_frozen", 4'd4, 32'd3);
      rd_chk("ctrl_freeze_rd", 4'd7, 32'h2);
      wr(4'd7, 32'h1);
      rd_chk("uptime_clr", 4'd4, 32'd0);
      idle(7);
      rd_chk("uptime_pre_tick", 4'd4, 32'd0);
      rd_chk("uptime_tick", 4'd4, 32'd1);
      idle(6);
      wr(4'd7, 32'h1);
      rd_chk("clr_on_wrap", 4'd4, 32'd0);
      rd_chk("ctrl_rd_zero", 4'd7, 32'h0);

      // back-to-back reads of the constant words
      address = 4'd0; read = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) address = 4'd1;
         if (i == 1) address = 4'd2;
         if (i == 2) read = 1'b0;
         gv[i] = rdv2; gd[i] = rdd2;
      end
      lit("b2b_v0", {31'b0, gv[0]}, 32'h0);
      lit("b2b_id", gv[1] ? gd[1] : 32'hXXXX_XXXX, P_ID);
      lit("b2b_ts", gv[2] ? gd[2] : 32'hXXXX_XXXX, P_TS);
      lit("b2b_ver", gv[3] ? gd[3] : 32'hXXXX_XXXX, P_VER);
      lit("b2b_v4", {31'b0, gv[4]}, 32'h0);

      rd_chk("addr9", 4'd9, 32'h0);

      // scratch, read-only protection, aliasing and read/write collision
      wr(4'd3, 32'hDEAD_BEEF);
      rd_chk("scratch", 4'd3, 32'hDEAD_BEEF);
      wr(4'd0, 32'h1234_5678);
      rd_chk("id_ro", 4'd0, P_ID);
      wr(4'd11, 32'h1234_5678);
      rd_chk("alias_ignored", 4'd3, 32'hDEAD_BEEF);
      rd_chk("rd_wr_collide", 4'd3, 32'hDEAD_BEEF, 1'b1, 32'h1);
      rd_chk("scratch_kept", 4'd3, 32'hDEAD_BEEF);

      // coherent 64-bit read across a low-word carry
      force dut.cyc_q  = 64'h0000_0001_FFFF_FFFE;
      force dut3.cyc_q = 64'h0000_0001_FFFF_FFFE;
      m_cyc = 64'h0000_0001_FFFF_FFFE;
      #1;
      release dut.cyc_q;
      release dut3.cyc_q;
      rd_chk("cyc_lo", 4'd5, 32'hFFFF_FFFE);
      idle(5);
      rd_chk("cyc_hi_snap", 4'd6, 32'h1);

      // reset one cycle after a read accept
      address = 4'd3; read = 1'b1;
      @(negedge clk);
      read = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      npulse = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         npulse = npulse + int'(rdv2) + int'(rdv3);
      end
      lit("no_valid_after_rst", npulse, 32'd0);
      rd_chk("scratch_rst", 4'd3, 32'h0);
      rd_chk("uptime_rst", 4'd4, 32'h0);
      rd_chk("cyc_lo_rst", 4'd5, 32'd8);
      rd_chk("snap_rst", 4'd6, 32'h0);

      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
